desc_byte_tx: RTL and testbench

Byte-serial transmitter for descriptor-sized vectors. It is the outbound counterpart of the NCC descriptor loader. It captures a wide descriptor or result vector in one cycle, then streams it to the PCI side one byte per accepted handshake, most-significant byte first. It sits between the vision datapath and the host-facing byte interface.

---
 rtl/desc_byte_tx.sv | 100 ++++++++++
 tb/tb_desc_byte_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/desc_byte_tx.sv
// desc_byte_tx: captures a DESC_BITS-wide vector in one cycle, then streams
// it out one byte per valid/ready handshake, most-significant byte first.
// Byte order matches the descriptor loader, so a loopback reproduces the vector.
module desc_byte_tx #(
    parameter int DESC_BITS = 2048,
    parameter int NUM_BYTES = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [DESC_BITS-1:0]           descIn,
    output logic                           busy,
    output logic [7:0]                     byteOut,
    output logic                           byteValid,
    input  logic                           byteReady,
    output logic [$clog2(NUM_BYTES+1)-1:0] byteCount,
    output logic                           done
);

    localparam int CNT_W = $clog2(NUM_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [DESC_BITS-1:0] r_shreg;
    logic [CNT_W-1:0]     r_byteCount;
    logic [CNT_W-1:0]     w_cntNext;
    logic                 w_capture;
    logic                 w_shift;

    assign w_cntNext = r_byteCount + CNT_W'(1);

    // State register; async reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived handshake/status outputs.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_shift   = 1'b0;
        byteValid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_capture = 1'b1;
                    w_next    = ST_SEND;
                end
            end
            ST_SEND: begin
                byteValid = 1'b1;
                busy      = 1'b1;
                if (byteReady) begin
                    w_shift = 1'b1;
                    if (w_cntNext == CNT_W'(NUM_BYTES)) begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Shift register and accepted-byte counter; both hold during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg     <= '0;
            r_byteCount <= '0;
        end else if (w_capture) begin
            r_shreg     <= descIn;
            r_byteCount <= '0;
        end else if (w_shift) begin
            r_shreg     <= {r_shreg[DESC_BITS-9:0], 8'h00};
            r_byteCount <= w_cntNext;
        end
    end

    assign byteOut   = r_shreg[DESC_BITS-1 -: 8];
    assign byteCount = r_byteCount;

endmodule

// File: tb/tb_desc_byte_tx.sv
// Directed bench for desc_byte_tx: a 32-bit instance for the detailed
// cases and a default-size instance looped back into a loader model.
module tb_desc_byte_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // small instance signals
    logic        s_start = 1'b0;
    logic [31:0] s_desc  = '0;
    logic        s_busy;
    logic [7:0]  s_byteOut;
    logic        s_byteValid;
    logic        s_byteReady = 1'b0;
    logic [2:0]  s_byteCount;
    logic        s_done;

    // default-size instance signals
    logic          b_start = 1'b0;
    logic [2047:0] b_desc  = '0;
    logic          b_busy;
    logic [7:0]    b_byteOut;
    logic          b_byteValid;
    logic          b_byteReady = 1'b0;
    logic [8:0]    b_byteCount;
    logic          b_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    desc_byte_tx #(.DESC_BITS(32), .NUM_BYTES(4)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .descIn(s_desc),
        .busy(s_busy), .byteOut(s_byteOut), .byteValid(s_byteValid),
        .byteReady(s_byteReady), .byteCount(s_byteCount), .done(s_done)
    );

    desc_byte_tx u_big (
        .clk(clk), .rst(rst), .start(b_start), .descIn(b_desc),
        .busy(b_busy), .byteOut(b_byteOut), .byteValid(b_byteValid),
        .byteReady(b_byteReady), .byteCount(b_byteCount), .done(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From the first SEND cycle with byteReady=1: expect 4 bytes back to back,
    // then a single DONE cycle, then IDLE.
    task automatic stream_check(input logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            chk("stream_byte", s_byteOut, v[31-8*k -: 8]);
            chk("stream_valid", s_byteValid, 1);
            chk("stream_count", s_byteCount, k);
            chk("stream_nodone", s_done, 0);
            tick();
        end
        chk("done_pulse", s_done, 1);
        chk("done_valid", s_byteValid, 0);
        chk("done_busy", s_busy, 1);
        chk("done_count", s_byteCount, 4);
        tick();
        chk("idle_done", s_done, 0);
        chk("idle_busy", s_busy, 0);
        chk("idle_count", s_byteCount, 4);
    endtask

    initial begin
        logic [6:0]    pat;
        logic [7:0]    acc [4];
        logic [7:0]    prev;
        logic [7:0]    exp4 [4];
        int            nacc;
        logic [2047:0] rx;
        logic [8:0]    cnt_at_done;
        bit            seen;

        exp4[0] = 8'hA1; exp4[1] = 8'hB2; exp4[2] = 8'hC3; exp4[3] = 8'hD4;

        // reset values
        tick(); tick();
        chk("rst_busy", s_busy, 0);
        chk("rst_valid", s_byteValid, 0);
        chk("rst_byte", s_byteOut, 8'h00);
        chk("rst_done", s_done, 0);
        chk("rst_count", s_byteCount, 0);
        rst = 1'b0;
        tick();

        // streaming with byteReady held high
        s_desc = 32'hA1B2C3D4; s_start = 1'b1; s_byteReady = 1'b1;
        chk("pre_start_valid", s_byteValid, 0);
        tick();
        s_start = 1'b0;
        stream_check(32'hA1B2C3D4);

        // backpressure: ready 1,0,0,1,0,1,1
        s_start = 1'b1; s_byteReady = 1'b0;
        tick();
        s_start = 1'b0;
        pat  = 7'b1001011;
        nacc = 0;
        for (int i = 0; i < 7; i++) begin
            s_byteReady = pat[6-i];
            if (s_byteValid && s_byteReady) begin
                acc[nacc] = s_byteOut;
                nacc++;
            end
            prev = s_byteOut;
            tick();
            if (!pat[6-i]) chk("stall_hold", s_byteOut, prev);
            if (nacc < 4) chk("no_early_done", s_done, 0);
        end
        chk("bp_accepts", nacc, 4);
        for (int k = 0; k < 4; k++) chk("bp_byte", acc[k], exp4[k]);
        chk("bp_done", s_done, 1);
        chk("bp_count", s_byteCount, 4);
        tick();

        // start ignored mid-transfer, descIn changes isolated, then held start
        s_start = 1'b1; s_byteReady = 1'b1;
        tick();
        chk("iso_b0", s_byteOut, 8'hA1);
        s_desc = 32'hFFFFFFFF;
        tick();
        chk("iso_b1", s_byteOut, 8'hB2);
        s_start = 1'b0;
        tick();
        chk("iso_b2", s_byteOut, 8'hC3);
        s_start = 1'b1;
        tick();
        chk("iso_b3", s_byteOut, 8'hD4);
        tick();
        chk("iso_done", s_done, 1);
        tick();
        chk("iso_gap_valid", s_byteValid, 0);
        chk("iso_gap_busy", s_busy, 0);
        tick();
        s_start = 1'b0;
        stream_check(32'hFFFFFFFF);

        // async reset after two accepted bytes
        s_desc = 32'hA1B2C3D4; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick(); tick();
        chk("mid_byte", s_byteOut, 8'hC3);
        chk("mid_count", s_byteCount, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", s_byteValid, 0);
        chk("arst_busy", s_busy, 0);
        chk("arst_count", s_byteCount, 0);
        chk("arst_byte", s_byteOut, 8'h00);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", s_busy, 0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        stream_check(32'hA1B2C3D4);
        s_byteReady = 1'b0;

        // default size loopback into a left-shifting loader model
        for (int i = 0; i < 64; i++) b_desc[32*i +: 32] = $urandom;
        rx = '0; nacc = 0; seen = 1'b0; cnt_at_done = '0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            b_byteReady = 1'($urandom_range(0, 1));
            if (b_byteValid && b_byteReady) begin
                rx = {rx[2039:0], b_byteOut};
                nacc++;
            end
            tick();
            if (b_done) begin
                seen = 1'b1;
                cnt_at_done = b_byteCount;
            end
        end
        chk("loop_done_seen", seen, 1);
        chk("loop_accepts", nacc, 256);
        chk("loop_count", cnt_at_done, 256);
        chk("loop_vector_eq", rx == b_desc, 1);
        tick();
        chk("loop_done_clear", b_done, 0);
        chk("loop_idle_busy", b_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
